// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (5-9 data bits, none/odd/even parity, 1-2 stop bits).
// Define UART_RX_MAJORITY_EN for a 2-of-3 majority vote around every bit centre.
module uart_rx_param #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_sync_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int unsigned TICKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned HALF_BIT      = TICKS_PER_BIT / 2;
  localparam int unsigned CNT_W         = $clog2(TICKS_PER_BIT);
  localparam int unsigned BIT_W         = 4;
  localparam int unsigned BIT_DEC       = TICKS_PER_BIT - 1;
`ifdef UART_RX_MAJORITY_EN
  // Vote completes one tick after the centre, so the whole schedule slides by one clk.
  localparam int unsigned START_DEC     = HALF_BIT;
`else
  localparam int unsigned START_DEC     = HALF_BIT - 1;
`endif

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      TICKS_PER_BIT < 4) begin : g_bad_cfg
    $fatal(1, "uart_rx_param: illegal DATA_BITS/PARITY/STOP_BITS or TICKS_PER_BIT < 4");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, rx_data_n;
  logic                 par_ok, par_ok_n;
  logic                 stop_bad, stop_bad_n;
  logic                 armed, armed_n;
  logic                 valid_n, frame_error_n, parity_error_n, busy_n;
  logic                 samp_c, bit_dec_c, stop_acc_c;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // Two previous line samples for the 2-of-3 vote.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist <= 2'b11;
    else       hist <= {hist[0], rx_sync_in};
  end

  assign samp_c = (rx_sync_in & hist[0]) | (rx_sync_in & hist[1]) | (hist[0] & hist[1]);
`else
  assign samp_c = rx_sync_in;
`endif

  assign bit_dec_c  = (cnt == CNT_W'(BIT_DEC));
  assign stop_acc_c = stop_bad | ~samp_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt + CNT_W'(1);
    bit_cnt_n      = bit_cnt;
    shreg_n        = shreg;
    par_ok_n       = par_ok;
    stop_bad_n     = stop_bad;
    armed_n        = armed;
    rx_data_n      = rx_data;
    valid_n        = 1'b0;
    frame_error_n  = 1'b0;
    parity_error_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_sync_in) begin
          armed_n = 1'b1;
        end else if (armed) begin
          state_n    = START;
          bit_cnt_n  = '0;
          par_ok_n   = 1'b1;
          stop_bad_n = 1'b0;
        end
      end
      START: begin
        if (cnt == CNT_W'(START_DEC)) begin
          cnt_n   = '0;
          state_n = samp_c ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_dec_c) begin
          cnt_n   = '0;
          shreg_n = {samp_c, shreg[DATA_BITS-1:1]};
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_cnt_n = '0;
            state_n   = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      PAR: begin
        if (bit_dec_c) begin
          cnt_n    = '0;
          par_ok_n = ((^shreg) ^ samp_c) == (PARITY == 1);
          state_n  = STOP;
        end
      end
      STOP: begin
        if (bit_dec_c) begin
          cnt_n      = '0;
          stop_bad_n = stop_acc_c;
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            state_n        = IDLE;
            bit_cnt_n      = '0;
            rx_data_n      = shreg;
            frame_error_n  = stop_acc_c;
            valid_n        = !stop_acc_c && par_ok;
            parity_error_n = !stop_acc_c && !par_ok;
            // A low stop bit may be a break: wait for the line to go high again.
            if (stop_acc_c) armed_n = 1'b0;
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_ok       <= 1'b1;
      stop_bad     <= 1'b0;
      armed        <= 1'b0;
      rx_data      <= '0;
      valid        <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_cnt      <= bit_cnt_n;
      shreg        <= shreg_n;
      par_ok       <= par_ok_n;
      stop_bad     <= stop_bad_n;
      armed        <= armed_n;
      rx_data      <= rx_data_n;
      valid        <= valid_n;
      frame_error  <= frame_error_n;
      parity_error <= parity_error_n;
      busy         <= busy_n;
    end
  end

endmodule
